// File: rtl/timer_sequencer.sv
// Drives a single-interval timer (START/RESET, READY) and counts completed intervals to step a 4-phase traffic light.
// Outputs are decoded from registered state/phase only; a watchdog on READY latches a sticky fail-safe fault.
module timer_sequencer #(
    parameter int RED_CNT   = 4,
    parameter int RA_CNT    = 1,
    parameter int GREEN_CNT = 4,
    parameter int AMBER_CNT = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic       CLK,
    input  logic       N_RESET,
    input  logic       ENABLE,
    input  logic       TREADY,
    output logic       TSTART,
    output logic       TRESET,
    output logic [1:0] PHASE,
    output logic       RED,
    output logic       AMBER,
    output logic       GREEN,
    output logic       BUSY,
    output logic       FAULT
);
    localparam int MAX_AB  = (RED_CNT > RA_CNT) ? RED_CNT : RA_CNT;
    localparam int MAX_CD  = (GREEN_CNT > AMBER_CNT) ? GREEN_CNT : AMBER_CNT;
    localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int WW      = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_CLEAR, S_FAULT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_phase;
    logic [IW-1:0] r_int_cnt;
    logic [IW-1:0] w_last_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic          w_timeout;
    logic          w_phase_done;

    always_comb begin
        w_last_cnt = IW'(RED_CNT - 1);
        case (r_phase)
            2'd0:    w_last_cnt = IW'(RED_CNT - 1);
            2'd1:    w_last_cnt = IW'(RA_CNT - 1);
            2'd2:    w_last_cnt = IW'(GREEN_CNT - 1);
            default: w_last_cnt = IW'(AMBER_CNT - 1);
        endcase
    end

    assign w_timeout    = (r_wait_cnt == WW'(TIMEOUT - 1));
    assign w_phase_done = (r_int_cnt == w_last_cnt);

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // READY wins over the watchdog when both land in the same WAIT cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ENABLE) w_next = S_ARM;
            S_ARM:   w_next = S_WAIT;
            S_WAIT: begin
                if (TREADY)         w_next = S_CLEAR;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_CLEAR: w_next = ENABLE ? S_ARM : S_IDLE;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_phase    <= 2'd0;
            r_int_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_ARM: r_wait_cnt <= '0;
                S_WAIT: if (!TREADY && !w_timeout) r_wait_cnt <= r_wait_cnt + WW'(1);
                S_CLEAR: begin
                    if (w_phase_done) begin
                        r_int_cnt <= '0;
                        r_phase   <= r_phase + 2'd1;
                    end else begin
                        r_int_cnt <= r_int_cnt + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign PHASE = r_phase;

    always_comb begin
        TSTART = 1'b0;
        TRESET = 1'b0;
        BUSY   = 1'b0;
        FAULT  = 1'b0;
        RED    = (r_phase == 2'd0) || (r_phase == 2'd1);
        AMBER  = (r_phase == 2'd1) || (r_phase == 2'd3);
        GREEN  = (r_phase == 2'd2);
        case (r_state)
            S_IDLE:  TRESET = 1'b1;
            S_ARM: begin
                TSTART = 1'b1;
                BUSY   = 1'b1;
            end
            S_WAIT:  BUSY = 1'b1;
            S_CLEAR: begin
                TRESET = 1'b1;
                BUSY   = 1'b1;
            end
            S_FAULT: begin
                FAULT  = 1'b1;
                TRESET = 1'b1;
                RED    = 1'b1;
                AMBER  = 1'b0;
                GREEN  = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: three instances (default, TIMEOUT=8, TIMEOUT=2), each driven by a timer stub
// that raises READY d[i] cycles after START (d=0: never) and drops it on RESET.
module tb_timer_sequencer;
    logic       CLK = 1'b0;
    logic       N_RESET;
    logic       en     [3];
    logic       tready [3];
    logic       tstart [3];
    logic       treset [3];
    logic [1:0] phase  [3];
    logic       red    [3];
    logic       amber  [3];
    logic       green  [3];
    logic       busy   [3];
    logic       fault  [3];
    int         d      [3];
    int         cnt    [3];
    int         tcount [3];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_overlap = 0;
    int         exp_q[$];

    always #5 CLK = ~CLK;

    timer_sequencer dut (
        .CLK(CLK), .N_RESET(N_RESET), .ENABLE(en[0]), .TREADY(tready[0]),
        .TSTART(tstart[0]), .TRESET(treset[0]), .PHASE(phase[0]), .RED(red[0]),
        .AMBER(amber[0]), .GREEN(green[0]), .BUSY(busy[0]), .FAULT(fault[0])
    );

    timer_sequencer #(.TIMEOUT(8)) dut_wd (
        .CLK(CLK), .N_RESET(N_RESET), .ENABLE(en[1]), .TREADY(tready[1]),
        .TSTART(tstart[1]), .TRESET(treset[1]), .PHASE(phase[1]), .RED(red[1]),
        .AMBER(amber[1]), .GREEN(green[1]), .BUSY(busy[1]), .FAULT(fault[1])
    );

    timer_sequencer #(.TIMEOUT(2)) dut_b (
        .CLK(CLK), .N_RESET(N_RESET), .ENABLE(en[2]), .TREADY(tready[2]),
        .TSTART(tstart[2]), .TRESET(treset[2]), .PHASE(phase[2]), .RED(red[2]),
        .AMBER(amber[2]), .GREEN(green[2]), .BUSY(busy[2]), .FAULT(fault[2])
    );

    // Timer stubs
    always @(posedge CLK or negedge N_RESET) begin
        for (int i = 0; i < 3; i++) begin
            if (!N_RESET) begin
                tready[i] <= 1'b0;
                cnt[i]    <= 0;
            end else if (treset[i]) begin
                tready[i] <= 1'b0;
                cnt[i]    <= 0;
            end else if (tstart[i]) begin
                cnt[i]    <= 1;
                tready[i] <= (d[i] == 1);
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] + 1;
                if (cnt[i] + 1 == d[i]) tready[i] <= 1'b1;
            end
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (tstart[i]) tcount[i] = tcount[i] + 1;
            if (tstart[i] && treset[i]) n_overlap = n_overlap + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tstart(input int i, input string tag, output int t);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (tstart[i]) seen = 1'b1;
        end
        t = cyc;
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic chk_lamps(input int i, input string tag, input int e);
        chk({tag, "_phase"}, 32'(phase[i]), 32'(e));
        chk({tag, "_red"},   32'(red[i]),   32'(e == 0 || e == 1));
        chk({tag, "_amber"}, 32'(amber[i]), 32'(e == 1 || e == 3));
        chk({tag, "_green"}, 32'(green[i]), 32'(e == 2));
    endtask

    initial begin
        int t, tprev, e, ts, tc0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0;
            tcount[i] = 0;
        end
        d[0] = 3; d[1] = 1; d[2] = 1;
        N_RESET = 1'b1;
        #1 N_RESET = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_treset", 32'(treset[0]), 1);
        chk("rst_tstart", 32'(tstart[0]), 0);
        chk("rst_busy",   32'(busy[0]),   0);
        chk("rst_fault",  32'(fault[0]),  0);
        chk_lamps(0, "rst", 0);

        // Idle with ENABLE low
        N_RESET = 1'b1;
        ts = 0;
        repeat (20) begin
            @(negedge CLK);
            if (tstart[0]) ts++;
        end
        chk("idle_tstarts", 32'(ts), 0);
        chk("idle_treset",  32'(treset[0]), 1);
        chk("idle_busy",    32'(busy[0]), 0);

        // Boundary: D=1 gives 3-cycle intervals; D=2 with TIMEOUT=2 hits READY and timeout together
        en[2] = 1'b1;
        wait_tstart(2, "b_first", tprev);
        for (int k = 0; k < 3; k++) begin
            wait_tstart(2, "b_d1", t);
            chk("b_period_d1", 32'(t - tprev), 3);
            tprev = t;
        end
        d[2] = 2;
        for (int k = 0; k < 2; k++) begin
            wait_tstart(2, "b_d2", t);
            chk("b_period_d2", 32'(t - tprev), 4);
            chk("b_no_fault", 32'(fault[2]), 0);
            tprev = t;
        end
        en[2] = 1'b0;

        // Watchdog: run into GREEN, then starve READY
        en[1] = 1'b1;
        for (int k = 0; k < 6; k++) wait_tstart(1, "wd_run", t);
        chk("wd_phase", 32'(phase[1]), 2);
        d[1] = 0;
        repeat (8) @(negedge CLK);
        chk("wd_fault_early", 32'(fault[1]), 0);
        chk("wd_busy_wait",   32'(busy[1]), 1);
        @(negedge CLK);
        chk("wd_fault",  32'(fault[1]), 1);
        chk("wd_red",    32'(red[1]), 1);
        chk("wd_green",  32'(green[1]), 0);
        chk("wd_amber",  32'(amber[1]), 0);
        chk("wd_treset", 32'(treset[1]), 1);
        chk("wd_tstart", 32'(tstart[1]), 0);
        en[1] = 1'b0;

        // Full sequence on the default instance, D=3
        for (int k = 0; k < 4; k++) exp_q.push_back(0);
        exp_q.push_back(1);
        for (int k = 0; k < 4; k++) exp_q.push_back(2);
        for (int k = 0; k < 2; k++) exp_q.push_back(3);
        exp_q.push_back(0);
        en[0] = 1'b1;
        wait_tstart(0, "seq_first", tprev);
        tc0 = tcount[0];
        e = exp_q.pop_front();
        chk_lamps(0, "seq", e);
        for (int k = 0; k < 11; k++) begin
            wait_tstart(0, "seq", t);
            chk("seq_period", 32'(t - tprev), 5);
            chk("seq_busy", 32'(busy[0]), 1);
            e = exp_q.pop_front();
            chk_lamps(0, "seq", e);
            tprev = t;
        end
        chk("seq_tstart_count", 32'(tcount[0] - tc0), 11);

        // Advance to the 2nd GREEN interval, then pause mid-WAIT
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(2);
        for (int k = 0; k < 6; k++) begin
            wait_tstart(0, "adv", t);
            e = exp_q.pop_front();
            chk("adv_phase", 32'(phase[0]), 32'(e));
        end
        en[0] = 1'b0;
        @(negedge CLK);
        ts = tcount[0];
        repeat (11) @(negedge CLK);
        chk("pause_busy",    32'(busy[0]), 0);
        chk("pause_treset",  32'(treset[0]), 1);
        chk("pause_tstarts", 32'(tcount[0] - ts), 0);
        chk_lamps(0, "pause", 2);

        // Resume: two GREEN intervals remain, then AMBER
        exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(3);
        en[0] = 1'b1;
        wait_tstart(0, "resume", tprev);
        e = exp_q.pop_front();
        chk("resume_phase", 32'(phase[0]), 32'(e));
        for (int k = 0; k < 2; k++) begin
            wait_tstart(0, "resume", t);
            chk("resume_period", 32'(t - tprev), 5);
            e = exp_q.pop_front();
            chk("resume_phase", 32'(phase[0]), 32'(e));
            tprev = t;
        end

        // Async reset while in WAIT of AMBER, between clock edges
        @(negedge CLK);
        chk("pre_rst_busy", 32'(busy[0]), 1);
        chk("wd_sticky", 32'(fault[1]), 1);
        #2 N_RESET = 1'b0;
        #1;
        chk("arst_busy",   32'(busy[0]), 0);
        chk("arst_treset", 32'(treset[0]), 1);
        chk("arst_wd_fault", 32'(fault[1]), 0);
        chk_lamps(0, "arst", 0);
        chk("no_start_reset_overlap", 32'(n_overlap), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
